// File: rtl/spin_game_ctrl.sv
// rtl/spin_game_ctrl.sv - spin-wheel game controller: debounced stop button, judge, score, LED display
// SPIN_GAME_STREAK_EN: when defined, a lose (incl. timeout) clears the score so it counts a win streak.
`timescale 1ns/1ps
module spin_game_ctrl #(
  parameter int DEB_TICKS   = 4,
  parameter int HOLD_TICKS  = 40,
  parameter int BLINK_TICKS = 8,
  parameter int TOUT_TICKS  = 200,
  parameter int SCORE_W     = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               tick_i,
  input  logic               btn_i,
  input  logic [2:0]         pos_i,
  input  logic               running_i,
  input  logic [2:0]         target_i,
  output logic               stop_o,
  output logic [7:0]         led_o,
  output logic               win_o,
  output logic               lose_o,
  output logic [SCORE_W-1:0] score_o
);

  typedef enum logic [2:0] {ARM, RUN, STOPPING, JUDGE, SHOW, RELEASE} state_t;

  localparam logic [7:0]         DEB_MAX   = 8'(DEB_TICKS);
  localparam logic [7:0]         BLINK_MAX = 8'(BLINK_TICKS);
  localparam logic [15:0]        HOLD_MAX  = 16'(HOLD_TICKS);
  localparam logic [15:0]        TOUT_MAX  = 16'(TOUT_TICKS);
  localparam logic [SCORE_W-1:0] SCORE_SAT = '1;

  state_t state, state_n;

  logic       sync1, sync2, deb_level, press;
  logic [7:0] deb_cnt;

  logic [15:0]        cnt, cnt_n;
  logic [7:0]         blink_cnt, blink_cnt_n;
  logic               blink_off, blink_off_n;
  logic               timeout, timeout_n;
  logic [2:0]         pos_q, pos_q_n;
  logic               enter, judge_win;
  logic               stop_n, win_n, lose_n;
  logic [7:0]         led_n;
  logic [SCORE_W-1:0] score_n;

  // Button: 2-FF synchronizer, then a tick-based debouncer; press fires with the accepted rising edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      deb_level <= 1'b0;
      deb_cnt   <= '0;
      press     <= 1'b0;
    end else begin
      sync1 <= btn_i;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == deb_level) begin
        deb_cnt <= '0;
      end else if (tick_i) begin
        if (deb_cnt + 8'd1 >= DEB_MAX) begin
          deb_cnt   <= '0;
          deb_level <= sync2;
          press     <= sync2;
        end else begin
          deb_cnt <= deb_cnt + 8'd1;
        end
      end
    end
  end

  always_comb begin
    state_n   = state;
    timeout_n = timeout;
    case (state)
      ARM:      if (running_i) state_n = RUN;
      RUN:      if (press) state_n = STOPPING;
      STOPPING: begin
        if (!running_i) begin
          state_n = JUDGE;
        end else if (cnt >= TOUT_MAX) begin
          state_n   = JUDGE;
          timeout_n = 1'b1;
        end
      end
      JUDGE:    state_n = SHOW;
      SHOW:     if (cnt >= HOLD_MAX) state_n = RELEASE;
      RELEASE:  if (running_i) state_n = RUN;
      default:  state_n = ARM;
    endcase
    if (state_n == STOPPING && state != STOPPING) timeout_n = 1'b0;

    // Counters restart on every state entry; a tick on the transition counts for the new state.
    enter       = (state_n != state);
    cnt_n       = enter ? '0 : cnt;
    blink_cnt_n = enter ? '0 : blink_cnt;
    blink_off_n = enter ? 1'b0 : blink_off;
    if (tick_i) begin
      if (cnt_n != 16'hFFFF) cnt_n = cnt_n + 16'd1;
      if (blink_cnt_n + 8'd1 >= BLINK_MAX) begin
        blink_cnt_n = '0;
        blink_off_n = ~blink_off_n;
      end else begin
        blink_cnt_n = blink_cnt_n + 8'd1;
      end
    end

    judge_win = !timeout && (pos_i == target_i);
    pos_q_n   = (state == JUDGE) ? pos_i : pos_q;
    score_n   = score_o;
    win_n     = win_o;
    lose_n    = lose_o;
    if (state == JUDGE) begin
      win_n  = judge_win;
      lose_n = !judge_win;
      if (judge_win && score_o != SCORE_SAT) score_n = score_o + SCORE_W'(1);
`ifdef SPIN_GAME_STREAK_EN
      if (!judge_win) score_n = '0;
`endif
    end
    if (state_n != SHOW) begin
      win_n  = 1'b0;
      lose_n = 1'b0;
    end

    stop_n = state_n inside {STOPPING, JUDGE, SHOW};
    case (state_n)
      ARM:     led_n = '0;
      SHOW:    led_n = (win_n && blink_off_n) ? 8'h00 : (8'd1 << pos_q_n);
      default: led_n = 8'd1 << pos_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ARM;
      cnt       <= '0;
      blink_cnt <= '0;
      blink_off <= 1'b0;
      timeout   <= 1'b0;
      pos_q     <= '0;
      stop_o    <= 1'b0;
      led_o     <= '0;
      win_o     <= 1'b0;
      lose_o    <= 1'b0;
      score_o   <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      blink_cnt <= blink_cnt_n;
      blink_off <= blink_off_n;
      timeout   <= timeout_n;
      pos_q     <= pos_q_n;
      stop_o    <= stop_n;
      led_o     <= led_n;
      win_o     <= win_n;
      lose_o    <= lose_n;
      score_o   <= score_n;
    end
  end

endmodule

// File: tb/tb_spin_game_ctrl.sv
// tb/tb_spin_game_ctrl.sv - randomized self-checking bench for spin_game_ctrl with a round-level reference model
`timescale 1ns/1ps
module tb_spin_game_ctrl;
  localparam int DEB   = 4;
  localparam int HOLD  = 40;
  localparam int BLINK = 8;
  localparam int TOUT  = 200;
  localparam int SW    = 4;
  localparam int SAT   = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          tick_i = 1'b0;
  logic          btn_i = 1'b0;
  logic          running_i = 1'b0;
  logic [2:0]    pos_i = 3'd0;
  logic [2:0]    target_i = 3'd0;
  logic          stop_o, win_o, lose_o;
  logic [7:0]    led_o;
  logic [SW-1:0] score_o;

  int errors = 0;
  int checks = 0;
  int model_score = 0;

  spin_game_ctrl #(
    .DEB_TICKS(DEB), .HOLD_TICKS(HOLD), .BLINK_TICKS(BLINK), .TOUT_TICKS(TOUT), .SCORE_W(SW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .tick_i(tick_i), .btn_i(btn_i), .pos_i(pos_i),
    .running_i(running_i), .target_i(target_i), .stop_o(stop_o), .led_o(led_o),
    .win_o(win_o), .lose_o(lose_o), .score_o(score_o)
  );

  always #10 clk = ~clk;

  // One-clock tick strobe every 4 clocks, changed on the falling edge.
  initial begin
    forever begin
      repeat (3) @(negedge clk);
      tick_i = 1'b1;
      @(negedge clk);
      tick_i = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] onehot(input int p);
    logic [7:0] one = 8'd1;
    return one << p;
  endfunction

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    do @(posedge clk); while (tick_i !== 1'b1);
    #1;
  endtask

  task automatic track_run(input int n);
    for (int i = 0; i < n; i++) begin
      wait_tick();
      pos_i = 3'($urandom_range(0, 7));
      clks(2);
      check("run_led", led_o, onehot(int'(pos_i)));
      check("run_stop", stop_o, 0);
    end
  endtask

  task automatic press_and_stop();
    wait_tick();
    btn_i = 1'b1;
    repeat (DEB - 1) wait_tick();
    check("stop_early", stop_o, 0);
    wait_tick();
    check("stop_at_accept", stop_o, 0);
    clks(2);
    check("stop_asserted", stop_o, 1);
  endtask

  task automatic play_round(input int stop_pos, input int tgt, input bit tmo,
                            input bit hold_btn, input int rst_at);
    bit win;
    bit off;
    logic [7:0] lit;
    target_i = 3'(tgt);
    press_and_stop();
    if (!hold_btn) btn_i = 1'b0;
    pos_i = 3'(stop_pos);
    if (tmo) begin
      repeat (TOUT - 1) wait_tick();
      check("tout_early_lose", lose_o, 0);
      check("tout_early_stop", stop_o, 1);
      wait_tick();
    end else begin
      repeat ($urandom_range(1, 4)) wait_tick();
      running_i = 1'b0;
    end
    clks(2);

    win = !tmo && (stop_pos == tgt);
    if (win) begin
      if (model_score < SAT) model_score++;
    end
`ifdef SPIN_GAME_STREAK_EN
    else model_score = 0;
`endif
    lit = onehot(stop_pos);
    check("show_win", win_o, win);
    check("show_lose", lose_o, !win);
    check("show_score", score_o, model_score);
    check("show_led0", led_o, lit);
    check("show_stop", stop_o, 1);
    pos_i = 3'($urandom_range(0, 7));

    for (int k = 1; k <= HOLD; k++) begin
      wait_tick();
      if (k == rst_at) begin
        rst_ni = 1'b0;
        #1;
        check("rst_stop", stop_o, 0);
        check("rst_led", led_o, 0);
        check("rst_score", score_o, 0);
        check("rst_win", win_o, 0);
        model_score = 0;
        running_i = 1'b0;
        clks(2);
        rst_ni = 1'b1;
        clks(2);
        check("rst_arm_stop", stop_o, 0);
        running_i = 1'b1;
        clks(2);
        track_run(2);
        return;
      end
      off = win && (((k / BLINK) % 2) == 1);
      check("show_hold_stop", stop_o, 1);
      check("show_led", led_o, off ? 8'h00 : lit);
    end
    clks(2);
    check("release_stop", stop_o, 0);
    check("release_win", win_o, 0);
    check("release_lose", lose_o, 0);
    check("release_led", led_o, onehot(int'(pos_i)));
    running_i = 1'b1;
    clks(2);
    if (hold_btn) begin
      track_run(8);
      btn_i = 1'b0;
      track_run(DEB + 2);
    end else begin
      track_run(2);
    end
  endtask

  initial begin
    int p;
    int t;
    rst_ni = 1'b0;
    clks(3);
    check("reset_stop", stop_o, 0);
    check("reset_led", led_o, 0);
    check("reset_win", win_o, 0);
    check("reset_lose", lose_o, 0);
    check("reset_score", score_o, 0);
    rst_ni = 1'b1;
    clks(2);
    check("arm_led", led_o, 0);
    running_i = 1'b1;
    clks(2);
    track_run(30);

    wait_tick();
    btn_i = 1'b1;
    repeat (3) wait_tick();
    btn_i = 1'b0;
    repeat (6) wait_tick();
    check("short_press_stop", stop_o, 0);
    track_run(2);

    play_round(3, 3, 1'b0, 1'b0, 0);
    p = $urandom_range(0, 7);
    play_round(p, p, 1'b0, 1'b0, 0);
    play_round(5, 3, 1'b0, 1'b0, 0);

    for (int r = 0; r < 6; r++) begin
      p = $urandom_range(0, 7);
      t = ($urandom_range(0, 1) == 1) ? p : $urandom_range(0, 7);
      play_round(p, t, 1'b0, 1'b0, 0);
    end

    p = $urandom_range(0, 7);
    play_round(p, p, 1'b1, 1'b1, 0);

    p = $urandom_range(0, 7);
    play_round(p, p, 1'b0, 1'b0, $urandom_range(5, 30));

    for (int r = 0; r < 17; r++) begin
      p = $urandom_range(0, 7);
      play_round(p, p, 1'b0, 1'b0, 0);
    end
    check("score_saturated", score_o, SAT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
